// File: rtl/imm_encoder_pkg.sv
// Shared constants and helpers for the immediate encoder.
// Build option: IMM_ENC_LI_EN enables li -> LUI/ADDI expansion.
package imm_encoder_pkg;

    // Immediate type selector codes; 3'b110 and 3'b111 fall back to I.
    localparam logic [2:0] IMM_TYPE_I     = 3'b000;
    localparam logic [2:0] IMM_TYPE_S     = 3'b001;
    localparam logic [2:0] IMM_TYPE_B     = 3'b010;
    localparam logic [2:0] IMM_TYPE_U     = 3'b011;
    localparam logic [2:0] IMM_TYPE_J     = 3'b100;
    localparam logic [2:0] IMM_TYPE_CSR   = 3'b101;
    localparam logic [2:0] IMM_TYPE_I_ALT = 3'b111;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI   = 3'b000;

`ifdef IMM_ENC_LI_EN
    typedef enum logic {
        ST_IDLE,
        ST_EMIT_LO
    } enc_state_t;
`endif

    // True when bits [31:lsb] of v are all zeros or all ones (sign-extension holds).
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

    function automatic logic [31:0] make_lui(input logic [4:0] rd, input logic [19:0] hi);
        return {hi, rd, OPCODE_LUI};
    endfunction

    function automatic logic [31:0] make_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [11:0] imm);
        return {imm, rs1, FUNCT3_ADDI, rd, OPCODE_OP_IMM};
    endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational immediate packer: scatters an immediate into the bit fields of
// the selected instruction format over a base word and flags values that do
// not fit. Unaffected by IMM_ENC_LI_EN.
module imm_field_packer
    import imm_encoder_pkg::*;
(
    input  logic [31:0] i_base,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_imm_type,
    output logic [31:0] o_instr,
    output logic        o_err
);

    // Overwrite only the immediate fields of the chosen format; out-of-range values are truncated.
    always_comb begin
        o_instr = i_base;
        o_err   = 1'b0;
        case (i_imm_type)
            IMM_TYPE_S: begin
                o_instr[31:25] = i_imm[11:5];
                o_instr[11:7]  = i_imm[4:0];
                o_err          = !upper_uniform(i_imm, 11);
            end
            IMM_TYPE_B: begin
                o_instr[31]    = i_imm[12];
                o_instr[30:25] = i_imm[10:5];
                o_instr[11:8]  = i_imm[4:1];
                o_instr[7]     = i_imm[11];
                o_err          = !upper_uniform(i_imm, 12) || i_imm[0];
            end
            IMM_TYPE_U: begin
                o_instr[31:12] = i_imm[31:12];
                o_err          = |i_imm[11:0];
            end
            IMM_TYPE_J: begin
                o_instr[31]    = i_imm[20];
                o_instr[30:21] = i_imm[10:1];
                o_instr[20]    = i_imm[11];
                o_instr[19:12] = i_imm[19:12];
                o_err          = !upper_uniform(i_imm, 20) || i_imm[0];
            end
            IMM_TYPE_CSR: begin
                o_instr[19:15] = i_imm[4:0];
                o_err          = |i_imm[31:5];
            end
            default: begin
                o_instr[31:20] = i_imm[11:0];
                o_err          = !upper_uniform(i_imm, 11);
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: request handshake, single output register stage,
// saturating error counter and, with IMM_ENC_LI_EN defined, the li expansion
// FSM that may emit a LUI followed by an ADDI.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | accepting requests; output register holds 0 or 1 word
// ST_EMIT_LO | LUI sits in the output register, ADDI waits in r_lo_instr
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h00000013,
    parameter int          ERRCNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [31:0]         IN_BASE,
    input  logic [31:0]         IN_IMM,
    input  logic [2:0]          IN_IMM_TYPE,
    input  logic                IN_LI,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [31:0]         OUT_INSTR,
    output logic                OUT_ERR,
    output logic [ERRCNT_W-1:0] ERR_COUNT
);

    logic                r_out_valid;
    logic [31:0]         r_out_instr;
    logic                r_out_err;
    logic [ERRCNT_W-1:0] r_err_count;

    logic [31:0] w_pack_instr;
    logic        w_pack_err;
    logic [31:0] w_first_instr;
    logic        w_first_err;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_idle;

    imm_field_packer u_packer (
        .i_base     (IN_BASE),
        .i_imm      (IN_IMM),
        .i_imm_type (IN_IMM_TYPE),
        .o_instr    (w_pack_instr),
        .o_err      (w_pack_err)
    );

`ifdef IMM_ENC_LI_EN
    enc_state_t  r_state;
    logic [31:0] r_lo_instr;
    logic        w_two_words;
    logic [31:0] w_lo_instr;
    logic [4:0]  w_rd;
    logic [11:0] w_lo;
    logic [19:0] w_hi;

    assign w_rd   = IN_BASE[11:7];
    assign w_lo   = IN_IMM[11:0];
    // ADDI sign-extends lo, so the upper part absorbs a borrow when lo[11] is set.
    assign w_hi   = IN_IMM[31:12] + {19'd0, IN_IMM[11]};
    assign w_idle = (r_state == ST_IDLE);
`else
    logic w_unused_li;

    assign w_unused_li = IN_LI;
    assign w_idle      = 1'b1;
`endif

    // Choose the first word to emit: packed immediate, or the li expansion head.
    always_comb begin
        w_first_instr = w_pack_instr;
        w_first_err   = w_pack_err;
`ifdef IMM_ENC_LI_EN
        w_two_words   = 1'b0;
        w_lo_instr    = make_addi(w_rd, w_rd, w_lo);
        if (IN_LI) begin
            w_first_err = 1'b0;
            if (w_hi == 20'd0) begin
                w_first_instr = make_addi(w_rd, 5'd0, w_lo);
            end else if (w_lo == 12'd0) begin
                w_first_instr = make_lui(w_rd, w_hi);
            end else begin
                w_first_instr = make_lui(w_rd, w_hi);
                w_two_words   = 1'b1;
            end
        end
`endif
    end

    assign IN_READY   = !RESET && w_idle && (!r_out_valid || OUT_READY);
    assign w_in_fire  = IN_VALID && IN_READY;
    assign w_out_fire = r_out_valid && OUT_READY;

    // Output register, li sequencing and saturating error counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_out_instr <= RESET_INSTR;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
`ifdef IMM_ENC_LI_EN
            r_state     <= ST_IDLE;
            r_lo_instr  <= RESET_INSTR;
`endif
        end else begin
            if (w_out_fire && r_out_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
`ifdef IMM_ENC_LI_EN
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_out_valid <= 1'b1;
                        r_out_instr <= w_first_instr;
                        r_out_err   <= w_first_err;
                        if (w_two_words) begin
                            r_lo_instr <= w_lo_instr;
                            r_state    <= ST_EMIT_LO;
                        end
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_EMIT_LO: begin
                    if (w_out_fire) begin
                        r_out_instr <= r_lo_instr;
                        r_out_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`else
            if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_first_instr;
                r_out_err   <= w_first_err;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
`endif
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_INSTR = r_out_instr;
    assign OUT_ERR   = r_out_err;
    assign ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder; li expansion tests are compiled in
// when IMM_ENC_LI_EN is defined, matching the DUT build.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_BASE;
    logic [31:0] IN_IMM;
    logic [2:0]  IN_IMM_TYPE;
    logic        IN_LI;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_INSTR;
    logic        OUT_ERR;
    logic [7:0]  ERR_COUNT;

    imm_encoder #(.RESET_INSTR(32'h00000013), .ERRCNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_BASE(IN_BASE), .IN_IMM(IN_IMM), .IN_IMM_TYPE(IN_IMM_TYPE), .IN_LI(IN_LI),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
        .OUT_ERR(OUT_ERR), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] instr; logic err; } word_t;
    typedef struct {
        logic [31:0] base; logic [31:0] imm; logic [2:0] t;
        logic [31:0] exp_instr; logic exp_err;
    } vec_t;

    word_t       sb_q[$];
    vec_t        vecs[12];
    logic [31:0] bounds[13];
    int          total = 0;
    int          bad   = 0;
    int          exp_cnt = 0;
    logic        in_fire, out_fire, got_out, last_err;
    logic [31:0] last_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference packing from the format tables, with range checks as signed arithmetic.
    function automatic word_t pack_model(input logic [31:0] base, input logic [31:0] imm,
                                         input logic [2:0] t);
        word_t w;
        longint s;
        s = longint'($signed(imm));
        case (t)
            IMM_TYPE_S: begin
                w.instr = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                w.err   = (s < -2048) || (s > 2047);
            end
            IMM_TYPE_B: begin
                w.instr = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                        | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'h1) << 7);
                w.err   = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            IMM_TYPE_U: begin
                w.instr = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
                w.err   = (imm % 4096) != 0;
            end
            IMM_TYPE_J: begin
                w.instr = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31)
                        | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                        | (imm & 32'h000FF000);
                w.err   = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            end
            IMM_TYPE_CSR: begin
                w.instr = (base & ~(32'h1F << 15)) | ((imm & 32'h1F) << 15);
                w.err   = imm > 32'd31;
            end
            default: begin
                w.instr = (base & 32'h000FFFFF) | (imm << 20);
                w.err   = (s < -2048) || (s > 2047);
            end
        endcase
        return w;
    endfunction

    task automatic push_expected(input logic [31:0] base, input logic [31:0] imm,
                                 input logic [2:0] t, input logic li);
`ifdef IMM_ENC_LI_EN
        if (li) begin
            logic [31:0] rd, lo, hi, lui, addi;
            word_t w;
            rd   = (base >> 7) & 32'h1F;
            lo   = imm & 32'hFFF;
            hi   = ((imm >> 12) + ((imm >> 11) & 32'h1)) & 32'hFFFFF;
            lui  = (hi << 12) | (rd << 7) | 32'h37;
            addi = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
            w.err = 1'b0;
            if (hi == 0) begin
                w.instr = (lo << 20) | (rd << 7) | 32'h13;
                sb_q.push_back(w);
            end else if (lo == 0) begin
                w.instr = lui;
                sb_q.push_back(w);
            end else begin
                w.instr = lui;
                sb_q.push_back(w);
                w.instr = addi;
                sb_q.push_back(w);
            end
            return;
        end
`endif
        sb_q.push_back(pack_model(base, imm, t));
    endtask

    // One clock: sample handshakes mid-low-phase, score, then advance to next negedge.
    task automatic cycle();
        word_t e;
        #1;
        in_fire  = IN_VALID && IN_READY;
        out_fire = OUT_VALID && OUT_READY;
        if (out_fire) begin
            got_out    = 1'b1;
            last_instr = OUT_INSTR;
            last_err   = OUT_ERR;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%h required=none", OUT_INSTR);
            end else begin
                e = sb_q.pop_front();
                check("sb_instr", OUT_INSTR, e.instr);
                check("sb_err", {31'd0, OUT_ERR}, {31'd0, e.err});
                if (e.err && exp_cnt < 255) exp_cnt++;
            end
        end
        if (in_fire) push_expected(IN_BASE, IN_IMM, IN_IMM_TYPE, IN_LI);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send(input logic [31:0] base, input logic [31:0] imm,
                        input logic [2:0] t, input logic li);
        int n;
        IN_BASE = base; IN_IMM = imm; IN_IMM_TYPE = t; IN_LI = li; IN_VALID = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!in_fire && n < 50);
        check("send_accept", {31'd0, in_fire}, 32'd1);
        IN_VALID = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ei, input logic ee);
        int n;
        got_out = 1'b0;
        n = 0;
        while (!got_out && n < 50) begin
            cycle();
            n++;
        end
        check({name, "_seen"}, {31'd0, got_out}, 32'd1);
        if (got_out) begin
            check(name, last_instr, ei);
            check({name, "_err"}, {31'd0, last_err}, {31'd0, ee});
        end
    endtask

    task automatic drain();
        int n;
        OUT_READY = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || OUT_VALID) && n < 100) begin
            cycle();
            n++;
        end
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00000013, 32'hFFFFFFFF, IMM_TYPE_I,     32'hFFF00013, 1'b0};
        vecs[1]  = '{32'h00000013, 32'h00000800, IMM_TYPE_I,     32'h80000013, 1'b1};
        vecs[2]  = '{32'h00002023, 32'hFFFFFFFC, IMM_TYPE_S,     32'hFE002E23, 1'b0};
        vecs[3]  = '{32'h00000063, 32'hFFFFF800, IMM_TYPE_B,     32'h800000E3, 1'b0};
        vecs[4]  = '{32'h00000063, 32'h00000003, IMM_TYPE_B,     32'h00000163, 1'b1};
        vecs[5]  = '{32'h0000006F, 32'h000FFFFE, IMM_TYPE_J,     32'h7FFFF06F, 1'b0};
        vecs[6]  = '{32'h00000037, 32'h12345001, IMM_TYPE_U,     32'h12345037, 1'b1};
        vecs[7]  = '{32'h00000037, 32'hABCDE000, IMM_TYPE_U,     32'hABCDE037, 1'b0};
        vecs[8]  = '{32'h00001073, 32'h0000001F, IMM_TYPE_CSR,   32'h000F9073, 1'b0};
        vecs[9]  = '{32'h00001073, 32'h00000020, IMM_TYPE_CSR,   32'h00001073, 1'b1};
        vecs[10] = '{32'h00000013, 32'h00000005, IMM_TYPE_I_ALT, 32'h00500013, 1'b0};
        vecs[11] = '{32'hFFF00013, 32'h00000000, IMM_TYPE_I,     32'h00000013, 1'b0};
        bounds = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
                   32'hFFFFF000, 32'd31, 32'd32, 32'h000FFFFE, 32'hFFF00000, 32'h000007FF,
                   32'h00100000};

        RESET = 1'b1; IN_VALID = 1'b0; IN_BASE = '0; IN_IMM = '0; IN_IMM_TYPE = '0;
        IN_LI = 1'b0; OUT_READY = 1'b0; got_out = 1'b0;
        #2;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_out_instr", OUT_INSTR, 32'h00000013);
        check("rst_out_err", {31'd0, OUT_ERR}, 32'd0);
        check("rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);
        @(negedge CLK);

        // Directed vectors, one at a time.
        OUT_READY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].base, vecs[i].imm, vecs[i].t, 1'b0);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_err);
        end
        drain();
        check("vec_err_count", {24'd0, ERR_COUNT}, exp_cnt);

        // Backpressure: word must hold and no request may slip in.
        OUT_READY = 1'b0;
        send(32'h00000013, 32'd7, IMM_TYPE_I, 1'b0);
        IN_BASE = 32'h00000013; IN_IMM = 32'd9; IN_IMM_TYPE = IMM_TYPE_I; IN_VALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", {31'd0, OUT_VALID}, 32'd1);
            check("bp_instr", OUT_INSTR, 32'h00700013);
            check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
            cycle();
        end
        OUT_READY = 1'b1;
        for (int k = 0; k < 20 && !in_fire; k++) cycle();
        IN_VALID = 1'b0;
        drain();

        // Full throughput: one request accepted every cycle.
        IN_VALID = 1'b1;
        for (int k = 0; k < 6; k++) begin
            IN_IMM = 32'(k * 4);
            cycle();
            check("tput_accept", {31'd0, in_fire}, 32'd1);
        end
        IN_VALID = 1'b0;
        drain();

`ifdef IMM_ENC_LI_EN
        begin
            logic [4:0]  li_rd[5];
            logic [31:0] li_imm[5];
            int          li_n[5];
            logic [31:0] li_w0[5];
            logic [31:0] li_w1[5];
            li_rd  = '{5'd5, 5'd5, 5'd10, 5'd1, 5'd0};
            li_imm = '{32'h12345FFF, 32'h00000800, 32'h00005000, 32'hFFFFF800, 32'h12345678};
            li_n   = '{2, 2, 1, 1, 2};
            li_w0  = '{32'h123462B7, 32'h000012B7, 32'h00005537, 32'h80000093, 32'h12345037};
            li_w1  = '{32'hFFF28293, 32'h80028293, 32'h0, 32'h0, 32'h67800013};
            OUT_READY = 1'b1;
            for (int i = 0; i < 5; i++) begin
                send({20'hABCDE, li_rd[i], 7'h33}, li_imm[i], IMM_TYPE_U, 1'b1);
                #1;
                check("li_in_ready", {31'd0, IN_READY}, (li_n[i] == 2) ? 32'd0 : 32'd1);
                expect_out($sformatf("li%0d_w0", i), li_w0[i], 1'b0);
                if (li_n[i] == 2) expect_out($sformatf("li%0d_w1", i), li_w1[i], 1'b0);
            end
            drain();
        end
`endif

        // Reset asserted with a pending (li: two-word) transfer.
        OUT_READY = 1'b0;
        send(32'h000002B3, 32'h12345FFF, IMM_TYPE_I, 1'b1);
        check("pre_rst_count_nonzero", {31'd0, (ERR_COUNT != 0)}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("mid_rst_out_instr", OUT_INSTR, 32'h00000013);
        check("mid_rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
        check("mid_rst_in_ready", {31'd0, IN_READY}, 32'd0);
        sb_q.delete();
        exp_cnt = 0;
        @(negedge CLK);
        RESET = 1'b0;
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post_rst_idle", {31'd0, OUT_VALID}, 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            int unsigned r;
            IN_VALID    = ($urandom % 10) < 7;
            OUT_READY   = ($urandom % 10) < 7;
            IN_BASE     = $urandom;
            IN_IMM_TYPE = 3'($urandom % 8);
            IN_LI       = ($urandom % 3) == 0;
            r = $urandom % 4;
            if (r == 0)      IN_IMM = $urandom;
            else if (r == 1) IN_IMM = 32'($urandom_range(0, 10000)) - 32'd5000;
            else if (r == 2) IN_IMM = bounds[$urandom % 13];
            else             IN_IMM = ($urandom & 32'hFFFFF000) | (($urandom % 2) ? 32'd0 : ($urandom & 32'hFFF));
            cycle();
        end
        IN_VALID = 1'b0;
        drain();
        check("rand_err_count", {24'd0, ERR_COUNT}, exp_cnt);

        // Error counter saturation.
        IN_BASE = 32'h00000013; IN_IMM = 32'h00001000; IN_IMM_TYPE = IMM_TYPE_I; IN_LI = 1'b0;
        IN_VALID = 1'b1;
        for (int k = 0; k < 270; k++) cycle();
        IN_VALID = 1'b0;
        drain();
        check("sat_err_count_model", {24'd0, ERR_COUNT}, exp_cnt);
        check("sat_err_count_max", {24'd0, ERR_COUNT}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
